// File: rtl/serial_add_sub_if.sv
// rtl/serial_add_sub_if.sv - request/result bundle for the bit-serial adder/subtractor
interface serial_add_sub_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, sel,
        input  busy, done, y, cout, ovf
    );

    modport slave (
        input  start, a, b, sel,
        output busy, done, y, cout, ovf
    );
endinterface

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial WIDTH-bit adder/subtractor, one bit per clock, LSB first
module serial_add_sub #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    serial_add_sub_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last;

    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] part;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] y_q;
    logic             cout_q;
    logic             ovf_q;

    logic             sum_bit;
    logic             carry_nxt;

    // Single full-adder slice working on the current LSBs.
    always_comb begin
        sum_bit   = ra[0] ^ rb[0] ^ carry;
        carry_nxt = (ra[0] & rb[0]) | (carry & (ra[0] ^ rb[0]));
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; DONE accepts a new start just like IDLE for back-to-back issue.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, serial shifting, and result load on the final bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ra     <= '0;
            rb     <= '0;
            part   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            y_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1: invert B and seed the carry with sel.
            ra    <= bus.a;
            rb    <= bus.sel ? ~bus.b : bus.b;
            carry <= bus.sel;
            cnt   <= '0;
        end else if (state == RUN) begin
            ra    <= ra >> 1;
            rb    <= rb >> 1;
            carry <= carry_nxt;
            cnt   <= cnt + CW'(1);
            part  <= {sum_bit, part[WIDTH-1:1]};
            if (last) begin
                // carry still holds the carry into the MSB slice here.
                y_q    <= {sum_bit, part[WIDTH-1:1]};
                cout_q <= carry_nxt;
                ovf_q  <= carry ^ carry_nxt;
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.y    = y_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - scoreboard bench for serial_add_sub with directed vectors
module tb_serial_add_sub;
    localparam int WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] y;
        logic             c;
        logic             o;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    serial_add_sub_if #(.WIDTH(WIDTH)) bus ();

    serial_add_sub #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("y", int'(bus.y), int'(e.y));
                check("cout", int'(bus.cout), int'(e.c));
                check("ovf", int'(bus.ovf), int'(e.o));
            end
        end
    end

    // Drive a request now; returns at the negedge after the accepting edge.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sel,
                         input logic push, input logic [WIDTH-1:0] ey, input logic ec, input logic eo);
        exp_t e;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sel   = sel;
        if (push) begin
            e.y = ey;
            e.c = ec;
            e.o = eo;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3 * WIDTH && !bus.done; i++) @(negedge clk);
        check("done_seen", int'(bus.done), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_y"}, int'(bus.y), 0);
        check({tag, "_cout"}, int'(bus.cout), 0);
        check({tag, "_ovf"}, int'(bus.ovf), 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.sel   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        // 1: 0 - 0, busy for exactly WIDTH cycles then one done cycle
        @(negedge clk);
        issue(4'd0, 4'd0, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < WIDTH; i++) begin
            check("busy_run", int'(bus.busy), 1);
            check("done_run", int'(bus.done), 0);
            @(negedge clk);
        end
        check("done_pulse", int'(bus.done), 1);
        check("busy_done", int'(bus.busy), 0);
        @(negedge clk);
        check("done_one_cycle", int'(bus.done), 0);

        // 2: additions
        issue(4'd10, 4'd5, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0);
        wait_done();
        @(negedge clk);
        issue(4'd10, 4'd10, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b1);
        wait_done();
        @(negedge clk);

        // 3: subtractions
        issue(4'd10, 4'd5, 1'b1, 1'b1, 4'b0101, 1'b1, 1'b1);
        wait_done();
        @(negedge clk);
        issue(4'd5, 4'd10, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b1);
        wait_done();

        // 4: back-to-back start in the DONE cycle, operands toggled during RUN
        issue(4'd12, 4'd0, 1'b1, 1'b1, 4'b1100, 1'b1, 1'b0);
        check("b2b_busy", int'(bus.busy), 1);
        bus.a = 4'd5; bus.b = 4'd7; bus.sel = 1'b0;
        @(negedge clk);
        bus.a = 4'd15; bus.b = 4'd15; bus.sel = 1'b1;
        wait_done();
        @(negedge clk);

        // 5: start while busy is ignored
        issue(4'd3, 4'd4, 1'b0, 1'b1, 4'b0111, 1'b0, 1'b0);
        issue(4'd15, 4'd15, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        wait_done();
        @(negedge clk);
        check("idle_after_ignored", int'(bus.busy), 0);

        // 6: reset two cycles into an operation aborts it
        issue(4'd5, 4'd5, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("abort");
        repeat (WIDTH + 2) @(negedge clk);
        check("abort_no_done", int'(bus.done), 0);
        issue(4'd9, 4'd6, 1'b1, 1'b1, 4'b0011, 1'b1, 1'b1);
        wait_done();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
Bit-serial, multi-cycle WIDTH-bit adder/subtractor with a start/busy/done handshake. It processes one bit per clock, LSB first, through a single full-adder slice. The sel-controlled invert-and-carry-in subtraction scheme matches the team's parallel RCA add/sub. It is the area-minimal sequential counterpart used wherever datapath throughput allows WIDTH cycles per operation.

Parameters:
WIDTH, 4, operand/result width in bits (>=2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request: sample a, b, sel this cycle (accepted only when not busy)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sel  input  1  0: y = a + b; 1: y = a - b
busy  output  1  operation in progress; start ignored while high
done  output  1  one-cycle pulse: y/cout/ovf just updated
y  output  WIDTH  result, modulo 2^WIDTH
cout  output  1  carry out of MSB (for subtract: 1 = no borrow)
ovf  output  1  two's-complement overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (rst). Reset dominates every other input.
- Reset values: busy=0, done=0, y=0, cout=0, ovf=0, state=IDLE. Internal shift registers, carry and bit counter are also cleared.
- States:
  - IDLE: start=1 -> latch A=a, B=(sel ? ~b : b), carry=sel, cnt=0, go to RUN.
  - RUN: each cycle computes s = A[0]^B[0]^carry and the new carry. s shifts into the MSB of the partial-result register; A and B shift right. cnt increments.
  - RUN -> DONE: on the cycle with cnt==WIDTH-1. On that edge, load y from the completed partial result, cout from the final carry, and ovf from the carry-in to the MSB slice XOR the final carry.
  - DONE: lasts exactly one cycle with done=1. start=1 here is accepted exactly as in IDLE (back-to-back issue); otherwise go to IDLE.
- busy=1 exactly while state==RUN.
- Latency: start sampled at edge k -> done high during the cycle after edge k+WIDTH. For WIDTH=4, done is visible 4 edges after the sampling edge. Sustained throughput is one result per WIDTH+1 cycles.
- Operand capture: a, b, sel are sampled only on the accepting edge. Changes during RUN have no effect.
- Output holding: y/cout/ovf hold their last values from done until the next completion. They never show partial results.
- start while busy: ignored; no queuing and no error.
- Width rules: all arithmetic is modulo 2^WIDTH. cnt must be wide enough to count to WIDTH-1.
- Reset mid-operation: the operation is aborted, outputs return to reset values, no done pulse, state=IDLE.
- Simultaneous rst and start: rst wins; the operation is not accepted.

Test Plan (WIDTH=4):
1. rst 2 cycles, then a=0,b=0,sel=1,start pulse -> busy=1 for 4 cycles, then done=1 for 1 cycle; y=0000, cout=1, ovf=0. Before start: all outputs 0.
2. a=10,b=5,sel=0 -> y=1111, cout=0, ovf=0. Then a=10,b=10,sel=0 -> y=0100, cout=1, ovf=1.
3. a=10,b=5,sel=1 -> y=0101, cout=1, ovf=1. Then a=5,b=10,sel=1 -> y=1011, cout=0, ovf=1.
4. a=12,b=0,sel=1 with start asserted in the DONE cycle of the previous op -> accepted back-to-back; y=1100, cout=1, ovf=0. Operands are toggled during RUN -> result unchanged.
5. start with a=3,b=4,sel=0; reassert start with a=15,b=15 while busy -> ignored; y=0111, cout=0, ovf=0.
6. rst asserted 2 cycles after start -> no done pulse, busy=0, y=0. A new start then completes normally (a=9,b=6,sel=1 -> y=0011, cout=1, ovf=1).
